tt_out_monitor: RTL

Output-side capture block for the Tiny Tapeout harness: the harness drives `ui_in`/`uio_in` into the user design, and this block reads the design's outputs back. It samples `uo_out` and the enabled bits of `uio_out`, records every change as a timestamped entry in a small show-ahead FIFO, and presents the entries to a host over a valid/ready read port. It sits next to the user project instance and is clocked by the same `clk`.

---
 rtl/tt_out_monitor.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/tt_out_monitor.sv
// tt_out_monitor
// Output-side capture block for the Tiny Tapeout harness. It samples the user
// design's dedicated outputs and the driven bits of the bidirectional outputs.
// Each change is recorded as a timestamped entry in a small show-ahead FIFO.
// A host drains the FIFO through a valid/ready read port. The rd_* outputs are
// registered copies of the FIFO head, so rd_ready has no combinational path to
// rd_valid.

module tt_out_monitor #(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr_ovf,
    input  logic [7:0]               uo_out,
    input  logic [7:0]               uio_out,
    input  logic [7:0]               uio_oe,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [7:0]               rd_uo,
    output logic [7:0]               rd_uio,
    output logic [TS_WIDTH-1:0]      rd_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 16 + TS_WIDTH;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Capture-side state
    logic [15:0]          sample_s;
    logic [15:0]          prev_r;
    logic                 armed_r;
    logic [TS_WIDTH-1:0]  ts_r;
    logic                 push_s;
    logic [EW-1:0]        entry_s;

    // FIFO state
    logic [EW-1:0]        mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic                 ovf_r;

    // FIFO control
    logic                 full_s;
    logic                 empty_s;
    logic                 pop_s;
    logic                 wr_en_s;
    logic                 drop_s;
    logic [CW-1:0]        count_nxt_s;
    logic [CW-1:0]        remain_s;
    logic [AW-1:0]        rd_ptr_nxt_s;
    logic [AW-1:0]        wr_ptr_nxt_s;
    logic                 ovf_nxt_s;

    // Registered head copy
    logic [EW-1:0]        head_r;
    logic [EW-1:0]        head_nxt_s;
    logic                 valid_r;
    logic                 valid_nxt_s;

    // Undriven uio bits are recorded as zero so they never produce events.
    assign sample_s = {uo_out, uio_out & uio_oe};
    assign entry_s  = {sample_s, ts_r};

    // Event detection: the first enabled cycle always records, later cycles only on change.
    always_comb begin
        push_s = 1'b0;
        if (en) begin
            if (!armed_r) begin
                push_s = 1'b1;
            end else if (sample_s != prev_r) begin
                push_s = 1'b1;
            end else begin
                push_s = 1'b0;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Capture state: previous sample, arm flag and free-running timestamp while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r  <= 16'h0000;
            armed_r <= 1'b0;
            ts_r    <= '0;
        end else if (en) begin
            prev_r  <= sample_s;
            armed_r <= 1'b1;
            ts_r    <= ts_r + TS_WIDTH'(1);
        end else begin
            armed_r <= 1'b0;
        end
    end

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == ZERO_C);
    // An empty FIFO ignores rd_ready, so a same-edge push into empty is never popped.
    assign pop_s   = valid_r & rd_ready;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign wr_en_s = push_s & (~full_s | pop_s);
    assign drop_s  = push_s & full_s & ~pop_s;

    // Next occupancy and pointers.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            2'b11:   count_nxt_s = count_r;
            2'b00:   count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (wr_en_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
    end

    // Sticky overflow: a drop on the same edge as a clear keeps the flag set.
    always_comb begin
        ovf_nxt_s = ovf_r;
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Next head: the stored entry after the pop, or the incoming entry when the FIFO would otherwise be empty.
    always_comb begin
        remain_s    = count_r - (pop_s ? ONE_C : ZERO_C);
        head_nxt_s  = head_r;
        valid_nxt_s = (count_nxt_s != ZERO_C);
        if (remain_s != ZERO_C) begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end else if (wr_en_s) begin
            head_nxt_s = entry_s;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // FIFO storage write; a push on a reset edge is discarded.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            ovf_r    <= ovf_nxt_s;
        end
    end

    // Registered head copy; holds its last value while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign rd_valid = valid_r;
    assign rd_uo    = head_r[EW-1 -: 8];
    assign rd_uio   = head_r[EW-9 -: 8];
    assign rd_ts    = head_r[TS_WIDTH-1:0];
    assign count    = count_r;
    assign overflow = ovf_r;

    tt_out_monitor_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .clr_ovf  (clr_ovf),
        .rd_valid (rd_valid),
        .count    (count),
        .overflow (overflow)
    );

endmodule

// Structural invariants of the read port and occupancy.
module tt_out_monitor_chk #(
    parameter int DEPTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   clr_ovf,
    input logic                   rd_valid,
    input logic [$clog2(DEPTH):0] count,
    input logic                   overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);
    a_valid_count: assert property (@(posedge clk) rd_valid == (count != ZERO_C));
    a_ovf_sticky:  assert property (@(posedge clk) $fell(overflow) |-> $past(clr_ovf | rst));

endmodule
